// File: rtl/ann_pkg.sv
// Shared definitions for the neuron compute path: network topology,
// weight-RAM layout helpers, default datapath widths and the MAC engine
// state encoding.
package ann_pkg;

   localparam int NUM_LAYERS = 4;
   localparam int L1_SIZE    = 30;
   localparam int L2_SIZE    = 30;
   localparam int L3_SIZE    = 10;
   localparam int L4_SIZE    = 10;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC_W = 8;
   localparam int DEF_ACC_W  = 40;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FETCH,
      ST_BIAS,
      ST_DRAIN,
      ST_RESULT
   } mac_state_e;

   // Number of inputs feeding each neuron of a layer.
   function automatic int fanin(input int layer, input int in_size);
      case (layer)
         1:       return in_size;
         2:       return L1_SIZE;
         3:       return L2_SIZE;
         4:       return L3_SIZE;
         default: return 0;
      endcase
   endfunction

   function automatic int layer_size(input int layer);
      case (layer)
         1:       return L1_SIZE;
         2:       return L2_SIZE;
         3:       return L3_SIZE;
         4:       return L4_SIZE;
         default: return 0;
      endcase
   endfunction

   // First weight word of a layer; every neuron stores its fan-in weights
   // followed by one bias word.
   function automatic int weight_base(input int layer, input int in_size);
      int base;
      base = 0;
      for (int l = 1; l < NUM_LAYERS; l++) begin
         if (l < layer) base += layer_size(l) * (fanin(l, in_size) + 1);
      end
      return base;
   endfunction

endpackage

// File: rtl/neuron_activate.sv
// Output stage of a neuron: Q16.16 accumulator -> Q8.8 result.
// Arithmetic shift right by FRAC_W (rounds toward -inf), ReLU on hidden
// layers, then saturation to the signed DATA_W range.
//   acc             in   signed accumulator including bias
//   is_output_layer in   1 = linear output, 0 = apply ReLU
//   res             out  saturated Q8.8 result
module neuron_activate
   import ann_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic                     is_output_layer,
   output logic        [DATA_W-1:0] res
);

   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shifted = acc >>> FRAC_W;
      res     = shifted[DATA_W-1:0];
      if (!is_output_layer && shifted[ACC_W-1]) begin
         res = '0;
      end else if (shifted[ACC_W-1:DATA_W-1] !=
                   {(ACC_W-DATA_W+1){shifted[ACC_W-1]}}) begin
         // Upper bits are not a pure sign extension: value is out of range.
         res = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/neuron_mac_engine.sv
// Neuron MAC engine: takes one (layer, neuron) command, streams the
// neuron's weights and the previous layer's activations from external
// RAMs (1-cycle read latency), accumulates the dot product plus bias and
// emits one activated Q8.8 result.
//   ACLK, ARESETN                clock, synchronous active-low reset
//   cmd_valid/ready/layer/neuron command handshake (1-based indices)
//   w_rd_en, w_addr, w_data      weight RAM read port
//   a_rd_en, a_layer, a_index,   activation RAM read port
//   a_data
//   res_valid/layer/neuron/data  result pulse, fields held until next result
//   err                          pulse for a rejected command
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | clear accumulator, compute neuron base address
// FETCH  | one weight + one activation read per cycle, k = 0..F-1
// BIAS   | bias word read, last product returning
// DRAIN  | bias returning, result registered
// RESULT | res_valid pulse
module neuron_mac_engine
   import ann_pkg::*;
#(
   parameter int IN_SIZE  = 30,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int ACC_W    = DEF_ACC_W,
   parameter int W_ADDR_W = 12
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [31:0]         cmd_layer,
   input  logic [31:0]         cmd_neuron,
   output logic                w_rd_en,
   output logic [W_ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0]   w_data,
   output logic                a_rd_en,
   output logic [2:0]          a_layer,
   output logic [4:0]          a_index,
   input  logic [DATA_W-1:0]   a_data,
   output logic                res_valid,
   output logic [2:0]          res_layer,
   output logic [4:0]          res_neuron,
   output logic [DATA_W-1:0]   res_data,
   output logic                err
);

   mac_state_e              state;
   logic [2:0]              lay_q;
   logic [4:0]              neu_q;
   logic [5:0]              k_q;
   logic                    pair_vld;
   logic signed [ACC_W-1:0] acc_q;

   logic                    cmd_ok;
   logic [5:0]              fan_last;
   logic [W_ADDR_W-1:0]     base_addr;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] acc_fin;
   logic [DATA_W-1:0]       act_res;

   assign cmd_ready = (state == ST_IDLE);

   assign cmd_ok = (cmd_layer >= 32'd1) && (cmd_layer <= 32'(NUM_LAYERS)) &&
                   (cmd_neuron != 32'd0) &&
                   (cmd_neuron <= 32'(layer_size(int'(cmd_layer[2:0]))));

   assign fan_last  = 6'(fanin(int'(lay_q), IN_SIZE) - 1);
   assign base_addr = W_ADDR_W'(weight_base(int'(lay_q), IN_SIZE) +
                      (int'(neu_q) - 1) * (fanin(int'(lay_q), IN_SIZE) + 1));

   assign prod     = $signed(w_data) * $signed(a_data);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   // Bias is Q8.8; align it with the Q16.16 products.
   assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){w_data[DATA_W-1]}}, w_data,
                      {FRAC_W{1'b0}}};
   assign acc_fin  = acc_q + bias_ext;

   neuron_activate #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_activate (
      .acc             (acc_fin),
      .is_output_layer (lay_q == 3'(NUM_LAYERS)),
      .res             (act_res)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state      <= ST_IDLE;
         lay_q      <= '0;
         neu_q      <= '0;
         k_q        <= '0;
         pair_vld   <= 1'b0;
         acc_q      <= '0;
         w_rd_en    <= 1'b0;
         w_addr     <= '0;
         a_rd_en    <= 1'b0;
         a_layer    <= '0;
         a_index    <= '0;
         res_valid  <= 1'b0;
         res_layer  <= '0;
         res_neuron <= '0;
         res_data   <= '0;
         err        <= 1'b0;
      end else begin
         err       <= 1'b0;
         res_valid <= 1'b0;
         // Activation strobes only occur together with weight strobes, so a
         // delayed a_rd_en marks a returning product pair.
         pair_vld  <= a_rd_en;
         if (pair_vld) acc_q <= acc_q + prod_ext;

         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_ok) begin
                     lay_q   <= cmd_layer[2:0];
                     neu_q   <= cmd_neuron[4:0];
                     a_layer <= cmd_layer[2:0] - 3'd1;
                     state   <= ST_LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               acc_q   <= '0;
               w_addr  <= base_addr;
               w_rd_en <= 1'b1;
               a_rd_en <= 1'b1;
               a_index <= '0;
               k_q     <= '0;
               state   <= ST_FETCH;
            end
            ST_FETCH: begin
               w_addr <= w_addr + W_ADDR_W'(1);
               if (k_q == fan_last) begin
                  a_rd_en <= 1'b0;
                  state   <= ST_BIAS;
               end else begin
                  k_q     <= k_q + 6'd1;
                  a_index <= a_index + 5'd1;
               end
            end
            ST_BIAS: begin
               w_rd_en <= 1'b0;
               state   <= ST_DRAIN;
            end
            ST_DRAIN: begin
               res_valid  <= 1'b1;
               res_data   <= act_res;
               res_layer  <= lay_q;
               res_neuron <= neu_q;
               state      <= ST_RESULT;
            end
            ST_RESULT: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_engine.sv
module tb_neuron_mac_engine;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_layer = '0;
   logic [31:0] cmd_neuron = '0;
   logic        w_rd_en;
   logic [11:0] w_addr;
   logic [15:0] w_data = '0;
   logic        a_rd_en;
   logic [2:0]  a_layer;
   logic [4:0]  a_index;
   logic [15:0] a_data = '0;
   logic        res_valid;
   logic [2:0]  res_layer;
   logic [4:0]  res_neuron;
   logic [15:0] res_data;
   logic        err;

   neuron_mac_engine dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_layer  (cmd_layer),
      .cmd_neuron (cmd_neuron),
      .w_rd_en    (w_rd_en),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .a_rd_en    (a_rd_en),
      .a_layer    (a_layer),
      .a_index    (a_index),
      .a_data     (a_data),
      .res_valid  (res_valid),
      .res_layer  (res_layer),
      .res_neuron (res_neuron),
      .res_data   (res_data),
      .err        (err)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // Topology for IN_SIZE = 30, written out as plain tables.
   int fan_t  [4] = '{30, 30, 30, 10};
   int size_t [4] = '{30, 30, 10, 10};
   int base_t [4] = '{0, 930, 1860, 2170};

   logic [15:0] wmem [0:4095];
   logic [15:0] amem [0:3][0:31];

   always @(posedge ACLK) begin
      if (w_rd_en) w_data <= wmem[w_addr];
      if (a_rd_en) a_data <= amem[a_layer][a_index];
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [15:0] ref_neuron(input int L, input int n);
      longint acc, r;
      int F, base;
      F    = fan_t[L-1];
      base = base_t[L-1] + (n - 1) * (F + 1);
      acc  = 0;
      for (int k = 0; k < F; k++)
         acc += longint'($signed(wmem[base+k])) * longint'($signed(amem[L-1][k]));
      acc += longint'($signed(wmem[base+F])) * 256;
      r = acc >>> 8;
      if (L < 4 && r < 0) r = 0;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   task automatic fill_random(input int mag);
      for (int i = 0; i < 4096; i++)
         wmem[i] = (mag == 0) ? 16'($urandom) : 16'($urandom_range(0, 2*mag-1) - mag);
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < 32; i++)
            amem[l][i] = (mag == 0) ? 16'($urandom) : 16'($urandom_range(0, 2*mag-1) - mag);
   endtask

   task automatic fill_neuron(input int L, input int n, input logic [15:0] w,
                              input logic [15:0] a, input logic [15:0] b);
      int F, base;
      F    = fan_t[L-1];
      base = base_t[L-1] + (n - 1) * (F + 1);
      for (int k = 0; k < F; k++) begin
         wmem[base+k] = w;
         amem[L-1][k] = a;
      end
      wmem[base+F] = b;
   endtask

   task automatic send(input int L, input int n, output int t_acc);
      int w;
      @(negedge ACLK);
      cmd_layer  = L;
      cmd_neuron = n;
      cmd_valid  = 1'b1;
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge ACLK);
         w++;
      end
      check("accept_wait", cmd_ready, 1);
      t_acc = cyc;
   endtask

   // Follows one accepted job from T+1 to the cycle after its result.
   // nxt_* is what the command inputs become at T+1.
   task automatic expect_job(input int t_acc, input int L, input int n,
                             input bit nxt_valid, input int nxt_L, input int nxt_n);
      int F, base, w_cnt, a_cnt, first_w, last_w, busy_bad, a_bad, t_res;
      bit got;
      logic [15:0] exp_res;
      F = fan_t[L-1];
      base = base_t[L-1] + (n - 1) * (F + 1);
      exp_res = ref_neuron(L, n);
      w_cnt = 0; a_cnt = 0; first_w = -1; last_w = -1;
      busy_bad = 0; a_bad = 0; t_res = -1; got = 0;
      for (int i = 0; i < F + 8 && !got; i++) begin
         @(negedge ACLK);
         if (i == 0) begin
            cmd_valid  = nxt_valid;
            cmd_layer  = nxt_valid ? nxt_L : $urandom;
            cmd_neuron = nxt_valid ? nxt_n : $urandom;
         end
         if (cmd_ready) busy_bad++;
         if (w_rd_en) begin
            if (first_w < 0) first_w = w_addr;
            last_w = w_addr;
            w_cnt++;
         end
         if (a_rd_en) begin
            if (int'(a_index) != a_cnt || int'(a_layer) != L - 1) a_bad++;
            a_cnt++;
         end
         if (res_valid) begin
            got = 1;
            t_res = cyc;
         end
      end
      check("res_seen", got, 1);
      check("res_latency", t_res - t_acc, F + 4);
      check("res_data", res_data, exp_res);
      check("res_layer", res_layer, L);
      check("res_neuron", res_neuron, n);
      check("w_first", first_w, base);
      check("w_last", last_w, base + F);
      check("w_count", w_cnt, F + 1);
      check("a_count", a_cnt, F);
      check("a_seq", a_bad, 0);
      check("busy_ready", busy_bad, 0);
      @(negedge ACLK);
      check("res_pulse", res_valid, 0);
      check("ready_back", cmd_ready, 1);
      check("res_hold", res_data, exp_res);
   endtask

   task automatic bad_cmd(input int L, input int n);
      int t, strobes;
      send(L, n, t);
      @(negedge ACLK);
      cmd_valid = 1'b0;
      check("err_pulse", err, 1);
      check("err_ready", cmd_ready, 1);
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (w_rd_en || a_rd_en || res_valid || err) strobes++;
      end
      check("err_quiet", strobes, 0);
   endtask

   initial begin
      int t, t2, stray;
      fill_random(512);
      repeat (3) @(negedge ACLK);
      check("rst_ready", cmd_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_err", err, 0);
      check("rst_w_rd_en", w_rd_en, 0);
      check("rst_a_rd_en", a_rd_en, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_a_layer", a_layer, 0);
      check("rst_a_index", a_index, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_ln", {res_layer, res_neuron}, 0);
      ARESETN = 1'b1;

      fill_neuron(4, 1, 16'h0100, 16'h0080, 16'h0000);
      send(4, 1, t);
      expect_job(t, 4, 1, 0, 0, 0);
      check("l4n1_value", res_data, 16'h0500);

      fill_neuron(1, 30, 16'hFF00, 16'h0100, 16'h0000);
      send(1, 30, t);
      expect_job(t, 1, 30, 0, 0, 0);
      check("l1n30_relu", res_data, 16'h0000);

      fill_neuron(4, 2, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      send(4, 2, t);
      expect_job(t, 4, 2, 0, 0, 0);
      check("sat_pos", res_data, 16'h7FFF);

      fill_neuron(4, 3, 16'h8000, 16'h7FFF, 16'h7FFF);
      send(4, 3, t);
      expect_job(t, 4, 3, 0, 0, 0);
      check("sat_neg", res_data, 16'h8000);

      bad_cmd(5, 1);
      bad_cmd(2, 0);
      bad_cmd(3, 11);

      fill_random(512);
      send(3, 10, t);
      expect_job(t, 3, 10, 1, 4, 1);
      t2 = cyc;
      check("b2b_accept", t2 - t, 35);
      expect_job(t2, 4, 1, 0, 0, 0);

      send(2, 5, t);
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         cmd_valid = 1'b0;
      end
      ARESETN = 1'b0;
      @(negedge ACLK);
      check("abort_ready", cmd_ready, 1);
      check("abort_strobes", {w_rd_en, a_rd_en}, 0);
      ARESETN = 1'b1;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge ACLK);
         if (res_valid) stray++;
      end
      check("abort_no_res", stray, 0);
      send(2, 5, t);
      expect_job(t, 2, 5, 0, 0, 0);

      for (int j = 0; j < 12; j++) begin
         int L, n;
         fill_random((j % 4 == 3) ? 0 : 512);
         L = $urandom_range(1, 4);
         n = $urandom_range(1, size_t[L-1]);
         send(L, n, t);
         expect_job(t, L, n, 0, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
